// File: rtl/etherneco_synctimer_slave_cmd_parser_if.sv
// Command-ring byte stream between the frame receiver and the synctimer
// slave command parser.
// The frame receiver drives the frame strobes, frame header and payload bytes.
// The parser returns the forwarded byte stream on m_cmd_*.
interface etherneco_synctimer_slave_cmd_parser_if;
    logic        cmd_rx_start;
    logic        cmd_rx_end;
    logic        cmd_rx_error;
    logic [15:0] cmd_rx_length;
    logic [7:0]  cmd_rx_type;
    logic [7:0]  cmd_rx_node;
    logic        s_cmd_first;
    logic        s_cmd_last;
    logic [15:0] s_cmd_pos;
    logic [7:0]  s_cmd_data;
    logic        s_cmd_valid;
    logic [7:0]  m_cmd_data;
    logic        m_cmd_valid;

    // Frame source side: produces the stream, consumes the forwarded copy
    modport master (
        output cmd_rx_start, cmd_rx_end, cmd_rx_error, cmd_rx_length,
               cmd_rx_type, cmd_rx_node, s_cmd_first, s_cmd_last,
               s_cmd_pos, s_cmd_data, s_cmd_valid,
        input  m_cmd_data, m_cmd_valid
    );

    // Parser side: consumes the stream, produces the forwarded copy
    modport slave (
        input  cmd_rx_start, cmd_rx_end, cmd_rx_error, cmd_rx_length,
               cmd_rx_type, cmd_rx_node, s_cmd_first, s_cmd_last,
               s_cmd_pos, s_cmd_data, s_cmd_valid,
        output m_cmd_data, m_cmd_valid
    );
endinterface

// File: rtl/etherneco_synctimer_slave_cmd_parser.sv
// Synctimer slave command parser.
// Watches the downstream command stream for SYNC frames.
// Assembles the little-endian master time from the payload and pairs it with
// the local time captured at frame start.
// The pair is published only when the frame ends cleanly with every time byte seen.
// The byte stream itself is forwarded with one cycle of latency.
module etherneco_synctimer_slave_cmd_parser #(
    parameter int         TIMER_WIDTH  = 64,
    parameter int         TIME_POS     = 0,
    parameter logic [7:0] SYNC_TYPE    = 8'h10,
    parameter int         ERRCNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [TIMER_WIDTH-1:0]             current_time,
    etherneco_synctimer_slave_cmd_parser_if.slave cmd,
    output logic [TIMER_WIDTH-1:0]             sync_master_time,
    output logic [TIMER_WIDTH-1:0]             sync_local_time,
    output logic                               sync_valid,
    output logic [ERRCNT_WIDTH-1:0]            err_count
);

    localparam int          NB      = TIMER_WIDTH / 8;
    localparam logic [15:0] MIN_LEN = 16'(TIME_POS + NB);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                   state, state_n;
    logic [TIMER_WIDTH-1:0]   master_sh, master_n;
    logic [TIMER_WIDTH-1:0]   local_sh, local_n;
    logic [NB-1:0]            mask, mask_n;
    logic [1:0]               err_inc;
    logic                     load_out;
    logic [ERRCNT_WIDTH:0]    err_sum;
    logic [ERRCNT_WIDTH-1:0]  err_next;

    // Next-state and shadow update; a start in any state behaves as a fresh
    // start, after aborting (and counting) a frame that was still in RECV
    always_comb begin
        state_n  = state;
        master_n = master_sh;
        local_n  = local_sh;
        mask_n   = mask;
        err_inc  = 2'd0;
        load_out = 1'b0;
        if (state == RECV) begin
            if (cmd.s_cmd_valid) begin
                for (int k = 0; k < NB; k++) begin
                    if (cmd.s_cmd_pos == 16'(TIME_POS + k)) begin
                        master_n[8*k +: 8] = cmd.s_cmd_data;
                        mask_n[k]          = 1'b1;
                    end
                end
            end
            if (cmd.cmd_rx_start) begin
                err_inc = 2'd1;
            end else if (cmd.cmd_rx_error) begin
                err_inc = 2'd1;
                state_n = IDLE;
            end else if (cmd.cmd_rx_end) begin
                if (&mask_n) begin
                    state_n  = DONE;
                    load_out = 1'b1;
                end else begin
                    err_inc = 2'd1;
                    state_n = IDLE;
                end
            end
        end else begin
            state_n = IDLE;
        end
        if (cmd.cmd_rx_start) begin
            if (cmd.cmd_rx_type == SYNC_TYPE) begin
                if (cmd.cmd_rx_length >= MIN_LEN) begin
                    local_n = current_time;
                    mask_n  = '0;
                    state_n = RECV;
                end else begin
                    err_inc = err_inc + 2'd1;
                    state_n = IDLE;
                end
            end else begin
                state_n = IDLE;
            end
        end
    end

    // Saturating add of this cycle's rejections to the error counter
    always_comb begin
        err_sum  = {1'b0, err_count} + {{(ERRCNT_WIDTH-1){1'b0}}, err_inc};
        err_next = err_sum[ERRCNT_WIDTH] ? '1 : err_sum[ERRCNT_WIDTH-1:0];
    end

    // FSM state, shadows and error counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            master_sh <= '0;
            local_sh  <= '0;
            mask      <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            master_sh <= master_n;
            local_sh  <= local_n;
            mask      <= mask_n;
            err_count <= err_next;
        end
    end

    // Publish the pair on entry to DONE so it is visible during the DONE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_master_time <= '0;
            sync_local_time  <= '0;
            sync_valid       <= 1'b0;
        end else begin
            sync_valid <= load_out;
            if (load_out) begin
                sync_master_time <= master_n;
                sync_local_time  <= local_sh;
            end
        end
    end

    // Unconditional one-cycle forward of the byte stream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd.m_cmd_data  <= '0;
            cmd.m_cmd_valid <= 1'b0;
        end else begin
            cmd.m_cmd_data  <= cmd.s_cmd_data;
            cmd.m_cmd_valid <= cmd.s_cmd_valid;
        end
    end

endmodule

// File: tb/tb_etherneco_synctimer_slave_cmd_parser.sv
// Directed testbench for etherneco_synctimer_slave_cmd_parser.
// Two instances share one stimulus stream:
//   dut_a uses the default parameters;
//   dut_b uses TIME_POS=4 and ERRCNT_WIDTH=2.
// Each test checks both instances against hand-computed expectations.
module tb_etherneco_synctimer_slave_cmd_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] current_time;
    logic        cmd_rx_start, cmd_rx_end, cmd_rx_error;
    logic [15:0] cmd_rx_length;
    logic [7:0]  cmd_rx_type, cmd_rx_node;
    logic        s_cmd_first, s_cmd_last, s_cmd_valid;
    logic [15:0] s_cmd_pos;
    logic [7:0]  s_cmd_data;
    logic [7:0]  frame_bytes [0:31];

    logic [63:0] a_master, a_local, b_master, b_local;
    logic        a_valid, b_valid;
    logic [15:0] a_err;
    logic [1:0]  b_err;

    int vectors    = 0;
    int miscompares = 0;

    etherneco_synctimer_slave_cmd_parser_if bus_a ();
    etherneco_synctimer_slave_cmd_parser_if bus_b ();

    assign bus_a.cmd_rx_start  = cmd_rx_start;
    assign bus_a.cmd_rx_end    = cmd_rx_end;
    assign bus_a.cmd_rx_error  = cmd_rx_error;
    assign bus_a.cmd_rx_length = cmd_rx_length;
    assign bus_a.cmd_rx_type   = cmd_rx_type;
    assign bus_a.cmd_rx_node   = cmd_rx_node;
    assign bus_a.s_cmd_first   = s_cmd_first;
    assign bus_a.s_cmd_last    = s_cmd_last;
    assign bus_a.s_cmd_pos     = s_cmd_pos;
    assign bus_a.s_cmd_data    = s_cmd_data;
    assign bus_a.s_cmd_valid   = s_cmd_valid;
    assign bus_b.cmd_rx_start  = cmd_rx_start;
    assign bus_b.cmd_rx_end    = cmd_rx_end;
    assign bus_b.cmd_rx_error  = cmd_rx_error;
    assign bus_b.cmd_rx_length = cmd_rx_length;
    assign bus_b.cmd_rx_type   = cmd_rx_type;
    assign bus_b.cmd_rx_node   = cmd_rx_node;
    assign bus_b.s_cmd_first   = s_cmd_first;
    assign bus_b.s_cmd_last    = s_cmd_last;
    assign bus_b.s_cmd_pos     = s_cmd_pos;
    assign bus_b.s_cmd_data    = s_cmd_data;
    assign bus_b.s_cmd_valid   = s_cmd_valid;

    etherneco_synctimer_slave_cmd_parser dut_a (
        .clk              (clk),
        .reset            (reset),
        .current_time     (current_time),
        .cmd              (bus_a),
        .sync_master_time (a_master),
        .sync_local_time  (a_local),
        .sync_valid       (a_valid),
        .err_count        (a_err)
    );

    etherneco_synctimer_slave_cmd_parser #(.TIME_POS(4), .ERRCNT_WIDTH(2)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .current_time     (current_time),
        .cmd              (bus_b),
        .sync_master_time (b_master),
        .sync_local_time  (b_local),
        .sync_valid       (b_valid),
        .err_count        (b_err)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_inputs();
        cmd_rx_start  = 1'b0;
        cmd_rx_end    = 1'b0;
        cmd_rx_error  = 1'b0;
        cmd_rx_length = 16'd0;
        cmd_rx_type   = 8'h00;
        cmd_rx_node   = 8'h00;
        s_cmd_first   = 1'b0;
        s_cmd_last    = 1'b0;
        s_cmd_valid   = 1'b0;
        s_cmd_pos     = 16'd0;
        s_cmd_data    = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Start, nbytes payload bytes at pos 0.., then optional end/error.
    // Returns on the negedge after the end cycle (the DONE cycle).
    task automatic send_frame(input logic [7:0] ftype, input logic [15:0] flen,
                              input logic [63:0] ctime, input int nbytes,
                              input bit do_end, input bit do_err, input bit end_on_last);
        @(negedge clk);
        idle_inputs();
        cmd_rx_start  = 1'b1;
        cmd_rx_type   = ftype;
        cmd_rx_length = flen;
        current_time  = ctime;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            idle_inputs();
            current_time = ctime + 64'd77 + 64'(i);
            s_cmd_valid  = 1'b1;
            s_cmd_pos    = 16'(i);
            s_cmd_data   = frame_bytes[i];
            s_cmd_first  = (i == 0);
            s_cmd_last   = (i == nbytes - 1);
            if (end_on_last && i == nbytes - 1) cmd_rx_end = 1'b1;
        end
        if ((do_end || do_err) && !end_on_last) begin
            @(negedge clk);
            idle_inputs();
            cmd_rx_end   = do_end;
            cmd_rx_error = do_err;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        current_time = 64'd0;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_valid: got %b expected 0", a_valid); end
        vectors++; if (a_master !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_a_master: got %h expected 0", a_master); end
        vectors++; if (a_local !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_a_local: got %h expected 0", a_local); end
        vectors++; if (a_err !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_a_err: got %0d expected 0", a_err); end
        vectors++; if (bus_a.m_cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_mvalid: got %b expected 0", bus_a.m_cmd_valid); end
        vectors++; if (bus_a.m_cmd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_a_mdata: got %h expected 00", bus_a.m_cmd_data); end
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_b_valid: got %b expected 0", b_valid); end
        vectors++; if (b_err !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_b_err: got %0d expected 0", b_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_good_frame();
        do_reset();
        for (int i = 0; i < 8; i++) frame_bytes[i] = 8'(i + 1);
        send_frame(8'h10, 16'd8, 64'd1000, 8, 1'b1, 1'b0, 1'b0);
        vectors++; if (a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL good_a_valid: got %b expected 1", a_valid); end
        vectors++; if (a_master !== 64'h0807060504030201) begin miscompares++; $display("[TB] FAIL good_a_master: got %h expected 0807060504030201", a_master); end
        vectors++; if (a_local !== 64'd1000) begin miscompares++; $display("[TB] FAIL good_a_local: got %0d expected 1000", a_local); end
        vectors++; if (a_err !== 16'd0) begin miscompares++; $display("[TB] FAIL good_a_err: got %0d expected 0", a_err); end
        vectors++; if (b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL short_b_valid: got %b expected 0", b_valid); end
        vectors++; if (b_err !== 2'd1) begin miscompares++; $display("[TB] FAIL short_b_err: got %0d expected 1", b_err); end
        @(negedge clk);
        vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL good_a_pulse: got %b expected 0", a_valid); end
        vectors++; if (a_master !== 64'h0807060504030201) begin miscompares++; $display("[TB] FAIL good_a_hold: got %h expected 0807060504030201", a_master); end
    endtask

    task automatic test_pass_through();
        logic [7:0] prev_data;
        logic       prev_valid;
        do_reset();
        @(negedge clk);
        idle_inputs();
        cmd_rx_start  = 1'b1;
        cmd_rx_type   = 8'h20;
        cmd_rx_length = 16'd20;
        prev_data  = 8'h00;
        prev_valid = 1'b0;
        for (int i = 0; i <= 21; i++) begin
            @(negedge clk);
            if (i > 0) begin
                vectors++; if (bus_a.m_cmd_valid !== prev_valid || bus_a.m_cmd_data !== prev_data) begin miscompares++; $display("[TB] FAIL pass_a_fwd[%0d]: got %b/%h expected %b/%h", i, bus_a.m_cmd_valid, bus_a.m_cmd_data, prev_valid, prev_data); end
                vectors++; if (bus_b.m_cmd_valid !== prev_valid || bus_b.m_cmd_data !== prev_data) begin miscompares++; $display("[TB] FAIL pass_b_fwd[%0d]: got %b/%h expected %b/%h", i, bus_b.m_cmd_valid, bus_b.m_cmd_data, prev_valid, prev_data); end
                vectors++; if ((a_valid | b_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL pass_sync_valid[%0d]: got %b expected 0", i, a_valid | b_valid); end
            end
            idle_inputs();
            if (i < 21 && i != 10) begin
                s_cmd_valid = 1'b1;
                s_cmd_pos   = 16'(i);
                s_cmd_data  = 8'hA0 + 8'(i);
            end
            if (i == 20) cmd_rx_end = 1'b1;
            prev_valid = s_cmd_valid;
            prev_data  = s_cmd_data;
        end
        @(negedge clk);
        vectors++; if (a_err !== 16'd0) begin miscompares++; $display("[TB] FAIL pass_a_err: got %0d expected 0", a_err); end
        vectors++; if (b_err !== 2'd0) begin miscompares++; $display("[TB] FAIL pass_b_err: got %0d expected 0", b_err); end
    endtask

    task automatic test_truncated();
        do_reset();
        for (int i = 0; i < 5; i++) frame_bytes[i] = 8'hC0 + 8'(i);
        send_frame(8'h10, 16'd12, 64'd500, 5, 1'b1, 1'b0, 1'b0);
        vectors++; if ((a_valid | b_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL trunc_valid: got %b expected 0", a_valid | b_valid); end
        vectors++; if (a_err !== 16'd1) begin miscompares++; $display("[TB] FAIL trunc_a_err: got %0d expected 1", a_err); end
        vectors++; if (b_err !== 2'd1) begin miscompares++; $display("[TB] FAIL trunc_b_err: got %0d expected 1", b_err); end
        for (int i = 0; i < 12; i++) frame_bytes[i] = 8'h55;
        send_frame(8'h10, 16'd12, 64'd3000, 12, 1'b1, 1'b0, 1'b0);
        vectors++; if (a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL after_a_valid: got %b expected 1", a_valid); end
        vectors++; if (b_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL after_b_valid: got %b expected 1", b_valid); end
        vectors++; if (a_master !== 64'h5555555555555555) begin miscompares++; $display("[TB] FAIL after_a_master: got %h expected 5555555555555555", a_master); end
        vectors++; if (b_master !== 64'h5555555555555555) begin miscompares++; $display("[TB] FAIL after_b_master: got %h expected 5555555555555555", b_master); end
        vectors++; if (a_local !== 64'd3000) begin miscompares++; $display("[TB] FAIL after_a_local: got %0d expected 3000", a_local); end
        vectors++; if (a_err !== 16'd1) begin miscompares++; $display("[TB] FAIL after_a_err: got %0d expected 1", a_err); end
        vectors++; if (b_err !== 2'd1) begin miscompares++; $display("[TB] FAIL after_b_err: got %0d expected 1", b_err); end
    endtask

    task automatic test_error_precedence();
        for (int i = 0; i < 12; i++) frame_bytes[i] = 8'h11 + 8'(i);
        send_frame(8'h10, 16'd12, 64'd3500, 12, 1'b1, 1'b1, 1'b0);
        vectors++; if ((a_valid | b_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL prec_valid: got %b expected 0", a_valid | b_valid); end
        vectors++; if (a_err !== 16'd2) begin miscompares++; $display("[TB] FAIL prec_a_err: got %0d expected 2", a_err); end
        vectors++; if (b_err !== 2'd2) begin miscompares++; $display("[TB] FAIL prec_b_err: got %0d expected 2", b_err); end
        vectors++; if (a_master !== 64'h5555555555555555) begin miscompares++; $display("[TB] FAIL prec_a_master: got %h expected 5555555555555555", a_master); end
        vectors++; if (a_local !== 64'd3000) begin miscompares++; $display("[TB] FAIL prec_a_local: got %0d expected 3000", a_local); end
    endtask

    task automatic test_restart();
        do_reset();
        for (int i = 0; i < 12; i++) frame_bytes[i] = 8'h30 + 8'(i);
        send_frame(8'h10, 16'd12, 64'd1500, 3, 1'b0, 1'b0, 1'b0);
        send_frame(8'h10, 16'd12, 64'd2000, 12, 1'b1, 1'b0, 1'b1);
        vectors++; if (a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_a_valid: got %b expected 1", a_valid); end
        vectors++; if (a_master !== 64'h3736353433323130) begin miscompares++; $display("[TB] FAIL restart_a_master: got %h expected 3736353433323130", a_master); end
        vectors++; if (a_local !== 64'd2000) begin miscompares++; $display("[TB] FAIL restart_a_local: got %0d expected 2000", a_local); end
        vectors++; if (a_err !== 16'd1) begin miscompares++; $display("[TB] FAIL restart_a_err: got %0d expected 1", a_err); end
        vectors++; if (b_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_b_valid: got %b expected 1", b_valid); end
        vectors++; if (b_master !== 64'h3B3A393837363534) begin miscompares++; $display("[TB] FAIL restart_b_master: got %h expected 3B3A393837363534", b_master); end
        vectors++; if (b_local !== 64'd2000) begin miscompares++; $display("[TB] FAIL restart_b_local: got %0d expected 2000", b_local); end
        vectors++; if (b_err !== 2'd1) begin miscompares++; $display("[TB] FAIL restart_b_err: got %0d expected 1", b_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        frame_bytes[0] = 8'hE0;
        frame_bytes[1] = 8'hE1;
        for (int n = 1; n <= 5; n++) begin
            send_frame(8'h10, 16'd12, 64'(n), 2, 1'b1, 1'b0, 1'b0);
            if (n == 3) begin
                vectors++; if (b_err !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_b_err_at3: got %0d expected 3", b_err); end
            end
        end
        vectors++; if (a_err !== 16'd5) begin miscompares++; $display("[TB] FAIL sat_a_err: got %0d expected 5", a_err); end
        vectors++; if (b_err !== 2'd3) begin miscompares++; $display("[TB] FAIL sat_b_err: got %0d expected 3", b_err); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 12; i++) frame_bytes[i] = 8'h90 + 8'(i);
        send_frame(8'h10, 16'd12, 64'd4000, 12, 1'b1, 1'b0, 1'b0);
        vectors++; if (a_local !== 64'd4000) begin miscompares++; $display("[TB] FAIL premid_a_local: got %0d expected 4000", a_local); end
        @(negedge clk);
        cmd_rx_start  = 1'b1;
        cmd_rx_type   = 8'h10;
        cmd_rx_length = 16'd12;
        current_time  = 64'd5000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_inputs();
            s_cmd_valid = 1'b1;
            s_cmd_pos   = 16'(i);
            s_cmd_data  = frame_bytes[i];
        end
        @(negedge clk);
        s_cmd_pos  = 16'd6;
        s_cmd_data = frame_bytes[6];
        reset = 1'b0;
        #1;
        vectors++; if (a_master !== 64'd0 || a_local !== 64'd0) begin miscompares++; $display("[TB] FAIL mid_a_time: got %h/%h expected 0/0", a_master, a_local); end
        vectors++; if (a_err !== 16'd0 || b_err !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_err: got %0d/%0d expected 0/0", a_err, b_err); end
        vectors++; if (bus_a.m_cmd_valid !== 1'b0 || bus_a.m_cmd_data !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_a_fwd: got %b/%h expected 0/00", bus_a.m_cmd_valid, bus_a.m_cmd_data); end
        vectors++; if (b_master !== 64'd0) begin miscompares++; $display("[TB] FAIL mid_b_master: got %h expected 0", b_master); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 7; i < 12; i++) begin
            @(negedge clk);
            idle_inputs();
            s_cmd_valid = 1'b1;
            s_cmd_pos   = 16'(i);
            s_cmd_data  = frame_bytes[i];
            cmd_rx_end  = (i == 11);
        end
        @(negedge clk);
        idle_inputs();
        vectors++; if ((a_valid | b_valid) !== 1'b0) begin miscompares++; $display("[TB] FAIL postmid_valid: got %b expected 0", a_valid | b_valid); end
        vectors++; if (a_err !== 16'd0 || b_err !== 2'd0) begin miscompares++; $display("[TB] FAIL postmid_err: got %0d/%0d expected 0/0", a_err, b_err); end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_good_frame();
        test_pass_through();
        test_truncated();
        test_error_precedence();
        test_restart();
        test_saturation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/etherneco_synctimer_slave_cmd_parser.md
Name: etherneco_synctimer_slave_cmd_parser

Overview:
- Upstream stage of the synctimer slave core, on the command (downstream-ring) byte stream.
- Extracts the master time carried in SYNC command frames and latches local current_time at frame start.
- Emits one validated (master_time, local_time) pair per good frame for the core's correction loop.
- Forwards the command stream unchanged with a fixed 1-cycle latency.

Parameters:
- TIMER_WIDTH, 64: width of master/local time; must be a multiple of 8, at most 64.
- TIME_POS, 0: byte position (s_cmd_pos) of the LSB of the master time field.
- SYNC_TYPE, 8'h10: cmd_rx_type value identifying a SYNC frame.
- ERRCNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- current_time  in  TIMER_WIDTH  local free-running time from the slave core.
- cmd_rx_start  in  1  frame start pulse.
- cmd_rx_end  in  1  frame end pulse (good frame).
- cmd_rx_error  in  1  frame abort pulse (CRC/format error).
- cmd_rx_length  in  16  payload length, valid at cmd_rx_start.
- cmd_rx_type  in  8  frame type, valid at cmd_rx_start.
- cmd_rx_node  in  8  node id (unused; forwarded only).
- s_cmd_first  in  1  first payload byte.
- s_cmd_last  in  1  last payload byte.
- s_cmd_pos  in  16  payload byte index.
- s_cmd_data  in  8  payload byte.
- s_cmd_valid  in  1  byte strobe; no backpressure.
- m_cmd_data  out  8  forwarded byte.
- m_cmd_valid  out  1  forwarded strobe.
- sync_master_time  out  TIMER_WIDTH  assembled master time.
- sync_local_time  out  TIMER_WIDTH  current_time latched on cmd_rx_start.
- sync_valid  out  1  1-cycle pulse: new pair valid.
- err_count  out  ERRCNT_WIDTH  count of rejected SYNC frames, saturating.

Behaviour:
Reset (reset==0, async):
- All outputs and state go to 0; the FSM goes to IDLE.
- Deassertion is synchronised by the integrating top.

Forward path:
- m_cmd_data and m_cmd_valid are s_cmd_data and s_cmd_valid registered one cycle.
- Unconditional; independent of the FSM.

FSM states: IDLE, RECV, DONE.
- IDLE: on cmd_rx_start with cmd_rx_type==SYNC_TYPE and cmd_rx_length >= TIME_POS+TIMER_WIDTH/8:
  - latch current_time into a local_time shadow;
  - clear the byte-hit mask (TIMER_WIDTH/8 bits);
  - go to RECV.
- IDLE, other frames: cmd_rx_start with a non-SYNC type is ignored (stay IDLE, no count). A SYNC type with too short a length is ignored and increments err_count.
- RECV: on s_cmd_valid with TIME_POS <= s_cmd_pos < TIME_POS+TIMER_WIDTH/8:
  - write byte k = s_cmd_pos-TIME_POS into bits [8k+7:8k] of the time shadow (little-endian);
  - set mask bit k.
- RECV: other byte positions are ignored.
- RECV, cmd_rx_end with all mask bits set:
  - go to DONE;
  - output registers update in the DONE cycle.
- RECV, rejected frame: go to IDLE and increment err_count if either:
  - cmd_rx_end arrives with the mask incomplete;
  - cmd_rx_error arrives.
- DONE: one cycle long.
  - sync_master_time and sync_local_time load from the shadows;
  - sync_valid=1;
  - next state is IDLE.
- Latency: sync_valid asserts 1 cycle after cmd_rx_end. Outputs hold their values until the next valid frame.

Simultaneous and boundary events:
- cmd_rx_error and cmd_rx_end in the same cycle: error wins; the frame is rejected.
- cmd_rx_start in RECV: the old frame is aborted and err_count increments. The start is then handled as in IDLE in the same cycle, re-latching current_time.
- cmd_rx_start in DONE: the DONE output update still occurs, and the start is processed as in IDLE.
- Data byte and cmd_rx_end in the same cycle: the byte is written first and counts toward the mask.
- Duplicate byte position in one frame: the later byte overwrites.
- err_count saturates at all-ones; it does not wrap.
- current_time wrap-around needs no special handling (raw latch).
- Reset mid-frame: state is discarded. The frame in flight is not counted, since bytes arriving after reset release are seen in IDLE.

Test Plan:
- Good frame: SYNC frame, length 8, bytes 01..08 at pos 0..7, current_time=1000 at start -> one cycle after cmd_rx_end, sync_valid pulses once, sync_master_time=64'h0807060504030201, sync_local_time=1000, err_count=0.
- Pass-through: 20-byte non-SYNC frame -> m_cmd_data/m_cmd_valid equal the input delayed exactly 1 cycle, sync_valid stays 0, err_count=0.
- Truncated frame: SYNC frame with cmd_rx_end after only 5 time bytes -> no sync_valid, err_count=1. A following good frame with time 0x55..55 -> sync_valid, outputs updated to 0x5555555555555555.
- Error precedence: cmd_rx_error and cmd_rx_end asserted together on a complete SYNC frame -> no sync_valid, err_count increments, previous outputs unchanged.
- Restart: new cmd_rx_start mid-RECV with current_time=2000, then a complete frame -> err_count increments by 1, sync_local_time=2000. With TIME_POS=4 and 4 header bytes, only pos 4..11 form the time.
- Saturation and reset: ERRCNT_WIDTH=2 with 5 bad frames -> err_count=3. Assert reset mid-frame -> all outputs 0 immediately (asynchronous), FSM in IDLE.
